// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset controller: FSM sequencing fetch/decode/execute/mem/writeback
// over a shared ALU and unified memory, with wait-state handshake and retire counter.
module multicycle_controller #(
  parameter int OPC_W         = 6,
  parameter int FUNC_W        = 6,
  parameter int ALUOP_W       = 3,
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opc,
  input  logic [FUNC_W-1:0]  func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR,
    S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_JUMPR, S_JAL, S_ILLEGAL
  } state_t;

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000001);
  localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(6'b000011);
  localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(6'b000111);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001111);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b011111);
  localparam logic [OPC_W-1:0] OP_SLTI = OPC_W'(6'b111111);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b111110);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b111100);

  localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(6'b010000);
  localparam logic [FUNC_W-1:0] FN_AND = FUNC_W'(6'b001000);
  localparam logic [FUNC_W-1:0] FN_OR  = FUNC_W'(6'b000100);
  localparam logic [FUNC_W-1:0] FN_SLT = FUNC_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

  state_t cur, nxt;
  logic   rdy;
  logic   retire;

  // Fixed one-cycle memory when the handshake is compiled out.
  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  always_comb begin
    nxt        = cur;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opc)
          OP_R:           nxt = S_EXEC_R;
          OP_LW, OP_SW:   nxt = S_ADDR;
          OP_ADDI, OP_SLTI: nxt = S_EXEC_I;
          OP_BEQ:         nxt = S_BRANCH;
          OP_J:           nxt = S_JUMP;
          OP_JR:          nxt = S_JUMPR;
          OP_JAL:         nxt = S_JAL;
          default:        nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        nxt       = S_WB_R;
        case (func)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: nxt    = S_ILLEGAL;
        endcase
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opc == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        if (rdy) nxt = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (rdy) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        nxt       = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_JUMPR: begin
        pc_src   = 2'b11;
        pc_write = 1'b1;
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4, so it is the link value written to $31.
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        nxt     = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule
